alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single 8-bit ALU between two requesters, for example the instruction datapath and a debug/test port, using valid/ready handshakes on both requests and responses.
- Round-robin arbitration.
- Registers the granted operands and select code onto the ALU inputs.
- Holds them for a fixed settle time, captures the ALU result and returns it to the winning requester.
- Sits between the requesters and the ALU instance.

Parameters:
WIDTH, 8, operand/result width
SEL_W, 3, ALU select width
SETTLE, 2, cycles the ALU inputs are held stable before the result is sampled (>=1; covers ALU propagation delay)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester request accept
req0_op1, req0_op2  in  WIDTH  requester 0 operands
req0_sel  in  SEL_W  requester 0 ALU select
req1_op1, req1_op2  in  WIDTH  requester 1 operands
req1_sel  in  SEL_W  requester 1 ALU select
alu_op1, alu_op2  out  WIDTH  registered operands to ALU
alu_sel  out  SEL_W  registered select to ALU
alu_result  in  WIDTH  ALU output
rsp_valid  out  2  per-requester response valid
rsp_ready  in  2  per-requester response accept
rsp_data  out  WIDTH  captured result, shared by both responses
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (RESET low, asynchronous):
  - state=IDLE.
  - alu_op1/alu_op2/alu_sel=0.
  - rsp_valid=0, rsp_data=0.
  - last_grant=1, so requester 0 wins first contention.
  - owner=0, settle counter=0.
- req_ready is combinational:
  - req_ready[i] = (state==IDLE) && grant==i.
  - grant = the only valid requester; if both are valid, the requester != last_grant.
  - req_ready = 0 outside IDLE or when no request is valid.
- State machine IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - On an edge where req_valid[i] && req_ready[i]: load alu_* from requester i, owner=i, counter=SETTLE, go to WAIT.
- WAIT:
  - The counter decrements each edge.
  - On the edge where counter==1, capture rsp_data=alu_result, set rsp_valid[owner]=1, go to RESP.
  - Latency: handshake at edge E; rsp_valid is high after edge E+SETTLE.
- RESP:
  - rsp_valid[owner] and rsp_data are held stable until an edge with rsp_ready[owner]=1.
  - On that edge: rsp_valid=0, last_grant=owner, go to IDLE.
  - The next request can be accepted no earlier than the following edge, so minimum issue spacing is SETTLE+2 cycles.
- alu_* outputs change only on a handshake. They retain their last values in IDLE and are never cleared except by reset.
- Operands are sampled only on the handshake edge:
  - Changing operands while in WAIT/RESP has no effect.
  - Dropping req_valid before it is accepted is legal and leaves no state behind.
- rsp_ready on the non-owner bit, or in any state other than RESP, is ignored.
- At most one rsp_valid bit is high at any time.
- select codes pass through unchecked; arithmetic is the ALU's concern (no carry/overflow captured).
- Reset mid-operation (WAIT or RESP): the pending operation is discarded, no response is produced, and all reset values apply immediately.
- Simultaneous rsp_ready accept and a new req_valid: the accept completes and the new request is taken the next cycle (IDLE), not the same cycle.

Test Plan:
- Single request: SETTLE=2, req0 op1=8 op2=10 sel=001 (ADD).
  - Required: req_ready[0]=1 in the same cycle.
  - alu_op1=8, alu_op2=10, alu_sel=1 after the edge.
  - rsp_valid[0]=1 and rsp_data=18 two edges later; busy high throughout.
- Contention, both valid from reset:
  - req0 (6,20,010 AND) is granted first -> rsp_data=4.
  - After rsp_ready, req1 (8,15,000 FORWARD) is granted -> rsp_data=15.
  - With both held valid, grants alternate 0,1,0,1 over 4 operations.
- Backpressure: hold rsp_ready[0]=0 for 5 cycles after rsp_valid[0] rises.
  - rsp_valid[0] and rsp_data stay constant and req_ready=00.
  - Asserting rsp_ready[0] clears rsp_valid the next edge.
- Busy rejection: while in WAIT, assert req1 valid with op1=1, op2=1.
  - req_ready[1]=0 and alu_* are unchanged.
  - After the response completes, req1 is accepted with the values present at that time.
- Reset mid-WAIT: pull RESET low asynchronously between clock edges.
  - alu_*=0, rsp_valid=0, busy=0 immediately.
  - No response follows; first grant after release goes to requester 0.
- Misdirected rsp_ready: in RESP with owner=1, assert rsp_ready=01 -> no state change; rsp_valid stays 10.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Holds the granted operands on the ALU for SETTLE cycles, then returns the captured result.
module alu_arbiter #(
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 3,
  parameter int SETTLE = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [SEL_W-1:0] req1_sel,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  alu_op1_q, alu_op1_d;
  logic [WIDTH-1:0]  alu_op2_q, alu_op2_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_s;
  logic              grant_vld_s;
  logic              hs_s;

  // Grant selection: a lone requester wins; under contention the one not served last wins.
  always_comb begin
    grant_s     = 1'b0;
    grant_vld_s = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_s     = 1'b0;
        grant_vld_s = 1'b1;
      end
      2'b10: begin
        grant_s     = 1'b1;
        grant_vld_s = 1'b1;
      end
      2'b11: begin
        grant_s     = ~last_grant_q;
        grant_vld_s = 1'b1;
      end
      default: begin
        grant_s     = 1'b0;
        grant_vld_s = 1'b0;
      end
    endcase
  end

  // Accept is only offered while idle, and only to the granted requester.
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == S_IDLE) && grant_vld_s) begin
      req_ready = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  assign hs_s = |(req_valid & req_ready);

  // Next-state and datapath updates for the IDLE -> WAIT -> RESP cycle.
  always_comb begin
    state_d      = state_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          alu_op1_d = grant_s ? req1_op1 : req0_op1;
          alu_op2_d = grant_s ? req1_op2 : req0_op2;
          alu_sel_d = grant_s ? req1_sel : req0_sel;
          owner_d   = grant_s;
          cnt_d     = CNT_W'(SETTLE);
          state_d   = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // The ALU inputs have been stable for SETTLE cycles on the edge where cnt reaches 1.
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d  = alu_result;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d  = 2'b00;
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 2'b00;
        cnt_d       = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      alu_op1_q    <= {WIDTH{1'b0}};
      alu_op2_q    <= {WIDTH{1'b0}};
      alu_sel_q    <= {SEL_W{1'b0}};
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= {WIDTH{1'b0}};
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
    end
  end

  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_alu_arbiter;

  localparam int WIDTH  = 8;
  localparam int SEL_W  = 3;
  localparam int SETTLE = 2;

  logic             CLK;
  logic             RESET;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [SEL_W-1:0] req0_sel, req1_sel;
  logic [WIDTH-1:0] alu_op1, alu_op2, alu_result, rsp_data;
  logic [SEL_W-1:0] alu_sel;
  logic [1:0]       rsp_valid, rsp_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [SEL_W-1:0] s);
    case (s)
      3'd0: return b;
      3'd1: return a + b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a - b;
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  // The ALU the arbiter fronts
  always_comb alu_result = alu_fn(alu_op1, alu_op2, alu_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one job in flight, visible SETTLE edges after acceptance
  int               cyc = 0;
  bit               m_busy = 1'b0;
  bit               m_owner = 1'b0;
  bit               m_last = 1'b1;
  int               m_acc = 0;
  logic [WIDTH-1:0] m_op1 = '0, m_op2 = '0, m_data = '0;
  logic [SEL_W-1:0] m_sel = '0;

  function automatic bit m_visible();
    return m_busy && (cyc >= m_acc + SETTLE);
  endfunction

  function automatic int m_winner();
    case (req_valid)
      2'b01: return 0;
      2'b10: return 1;
      2'b11: return m_last ? 0 : 1;
      default: return -1;
    endcase
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0;
      m_op1 = '0; m_op2 = '0; m_sel = '0; m_data = '0;
    end else begin
      if (m_busy) begin
        if (m_visible() && rsp_ready[m_owner]) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end else if (m_winner() >= 0) begin
        m_busy  = 1'b1;
        m_owner = (m_winner() == 1);
        m_acc   = cyc + 1;
        m_op1   = m_owner ? req1_op1 : req0_op1;
        m_op2   = m_owner ? req1_op2 : req0_op2;
        m_sel   = m_owner ? req1_sel : req0_sel;
      end
      cyc = cyc + 1;
      if (m_visible()) m_data = alu_fn(m_op1, m_op2, m_sel);
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge CLK) begin
    if (RESET) begin
      chk("m_req_ready", {30'd0, req_ready},
          {30'd0, (m_busy || m_winner() < 0) ? 2'b00 : ((m_winner() == 1) ? 2'b10 : 2'b01)});
      chk("m_rsp_valid", {30'd0, rsp_valid}, {30'd0, m_visible() ? (m_owner ? 2'b10 : 2'b01) : 2'b00});
      chk("m_rsp_data", {24'd0, rsp_data}, {24'd0, m_data});
      chk("m_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("m_alu_op1", {24'd0, alu_op1}, {24'd0, m_op1});
      chk("m_alu_op2", {24'd0, alu_op2}, {24'd0, m_op2});
      chk("m_alu_sel", {29'd0, alu_sel}, {29'd0, m_sel});
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (rsp_valid == 2'b00 && n < 12);
    if (rsp_valid == 2'b00) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #1;
    RESET = 1'b1;
    #1;
  endtask

  initial begin
    RESET = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req0_op1 = 8'd0; req0_op2 = 8'd0; req0_sel = 3'd0;
    req1_op1 = 8'd0; req1_op2 = 8'd0; req1_sel = 3'd0;
    #1;
    chk("rst_alu_op1", {24'd0, alu_op1}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge CLK);
    #1;
    RESET = 1'b1;

    // Single ADD request
    req_valid = 2'b01; req0_op1 = 8'd8; req0_op2 = 8'd10; req0_sel = 3'b001;
    #1;
    chk("single_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    chk("single_op1", {24'd0, alu_op1}, 32'd8);
    chk("single_op2", {24'd0, alu_op2}, 32'd10);
    chk("single_sel", {29'd0, alu_sel}, 32'd1);
    chk("single_busy1", {31'd0, busy}, 32'd1);
    tick();
    chk("single_early", {30'd0, rsp_valid}, 32'd0);
    chk("single_busy2", {31'd0, busy}, 32'd1);
    tick();
    chk("single_valid", {30'd0, rsp_valid}, 32'd1);
    chk("single_data", {24'd0, rsp_data}, 32'd18);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    chk("single_done", {30'd0, rsp_valid}, 32'd0);
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Contention from reset: grants alternate starting with requester 0
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    req0_op1 = 8'd6; req0_op2 = 8'd20; req0_sel = 3'b010;
    req1_op1 = 8'd8; req1_op2 = 8'd15; req1_sel = 3'b000;
    #1;
    chk("cont_first", {30'd0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      wait_rsp();
      chk("cont_owner", {30'd0, rsp_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_data", {24'd0, rsp_data}, (k % 2 == 0) ? 32'd4 : 32'd15);
    end
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b00;
    tick();

    // Backpressure on requester 0 (3+4)
    req_valid = 2'b01; req0_op1 = 8'd3; req0_op2 = 8'd4; req0_sel = 3'b001;
    tick();
    req_valid = 2'b00;
    wait_rsp();
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", {30'd0, rsp_valid}, 32'd1);
      chk("bp_data", {24'd0, rsp_data}, 32'd7);
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    chk("bp_clear", {30'd0, rsp_valid}, 32'd0);

    // Busy rejection, then req1 takes the operands present when it is accepted
    req_valid = 2'b01; req0_op1 = 8'd5; req0_op2 = 8'd3; req0_sel = 3'b001;
    tick();
    req_valid = 2'b00;
    tick();
    req_valid = 2'b10; req1_op1 = 8'd1; req1_op2 = 8'd1; req1_sel = 3'b100;
    #1;
    chk("rej_ready", {30'd0, req_ready}, 32'd0);
    wait_rsp();
    chk("rej_op1", {24'd0, alu_op1}, 32'd5);
    chk("rej_op2", {24'd0, alu_op2}, 32'd3);
    chk("rej_sel", {29'd0, alu_sel}, 32'd1);
    chk("rej_data", {24'd0, rsp_data}, 32'd8);
    req1_op1 = 8'd9; req1_op2 = 8'd12; req1_sel = 3'b011;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    chk("rej_ready1", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    chk("rej_op1b", {24'd0, alu_op1}, 32'd9);
    chk("rej_op2b", {24'd0, alu_op2}, 32'd12);
    chk("rej_selb", {29'd0, alu_sel}, 32'd3);
    wait_rsp();
    chk("rej_owner1", {30'd0, rsp_valid}, 32'd2);
    chk("rej_data1", {24'd0, rsp_data}, 32'd13);

    // Misdirected rsp_ready while requester 1 owns the response
    rsp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mis_valid", {30'd0, rsp_valid}, 32'd2);
      chk("mis_busy", {31'd0, busy}, 32'd1);
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    chk("mis_clear", {30'd0, rsp_valid}, 32'd0);

    // Asynchronous reset in the middle of WAIT
    req_valid = 2'b10; req1_op1 = 8'd2; req1_op2 = 8'd2; req1_sel = 3'b001;
    tick();
    req_valid = 2'b00;
    #1;
    RESET = 1'b0;
    #1;
    chk("mid_op1", {24'd0, alu_op1}, 32'd0);
    chk("mid_op2", {24'd0, alu_op2}, 32'd0);
    chk("mid_sel", {29'd0, alu_sel}, 32'd0);
    chk("mid_valid", {30'd0, rsp_valid}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    #1;
    RESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_norsp", {30'd0, rsp_valid}, 32'd0);
    end
    req_valid = 2'b11;
    #1;
    chk("mid_grant0", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    wait_rsp();
    chk("mid_owner0", {30'd0, rsp_valid}, 32'd1);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
